// File: rtl/instr_fetch_pkg.sv
// Shared constants, state encoding and entry type for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int ADDR_W        = 8;
    localparam int INSTR_W       = 16;
    localparam int OPC_W         = 4;
    localparam int FLUSH_CNT_DEF = 2;

    localparam logic [OPC_W-1:0] JMP_OPC = 4'hF;

    localparam logic [1:0] ST_RUN_WAIT = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    typedef enum logic [1:0] {
        RUN_WAIT = ST_RUN_WAIT,
        RUN      = ST_RUN,
        FLUSH    = ST_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
    } fetch_entry_t;

    function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W] == JMP_OPC;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Valid/ready instruction handshake from fetch to decode/execute.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0]  ir_addr;

    modport master (output ir_valid, output ir_data, output ir_addr, input ir_ready);
    modport slave  (input ir_valid, input ir_data, input ir_addr, output ir_ready);

endinterface

// File: rtl/instr_fetch_skid_fifo.sv
// Two-entry in-order skid FIFO; the head register holds its last value once drained.
module fetch_skid_fifo #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic         push_ok;
    logic         pop_ok;

    assign pop_ok    = pop && (count != 2'd0);
    assign push_ok   = push && ((count != 2'd2) || pop_ok);
    assign head_data = entry0;

    // entry0 is always the head, so a pop from one entry leaves it untouched
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push_ok) entry0 <= push_data;
                end
                2'd1: begin
                    if (push_ok && pop_ok) entry0 <= push_data;
                    else if (push_ok)      entry1 <= push_data;
                end
                default: begin
                    if (pop_ok) begin
                        entry0 <= entry1;
                        if (push_ok) entry1 <= push_data;
                    end
                end
            endcase
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the ROM, redirects the PC on J-type words and buffers instructions.
// FETCH_FWD_JUMP_EN: when defined, J-type words are also passed downstream.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int FLUSH_CNT = FLUSH_CNT_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_stall,
    output logic               pc_select,
    output logic [ADDR_W-1:0]  jump_address,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    instr_fetch_if.master      ir
);

    logic [1:0]        state;
    logic [1:0]        drop_cnt;
    logic              rd_pending;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              ret_jump;
    logic              take_jump;
    logic              push;
    logic              pop;
    logic              issue;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign imem_addr = pc_addr;
    assign ret_jump  = rd_pending && is_jump(imem_rdata);
    assign take_jump = ret_jump && (state == ST_RUN);

`ifdef FETCH_FWD_JUMP_EN
    assign push = rd_pending && (state == ST_RUN);
`else
    assign push = rd_pending && (state == ST_RUN) && !ret_jump;
`endif

    // Counting the in-flight read keeps a returning word from ever finding the FIFO full
    assign pop       = ir.ir_valid && ir.ir_ready;
    assign occupancy = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop};
    assign pc_stall  = occupancy >= 3'd2;
    assign issue     = !pc_stall && (state != ST_RUN_WAIT);

    assign push_entry = '{instr: imem_rdata, addr: req_addr};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pending <= 1'b0;
            req_addr   <= '0;
        end else begin
            rd_pending <= issue;
            req_addr   <= pc_addr;
        end
    end

    // Words already buffered are older than the jump and stay; only returns after it are dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_RUN_WAIT;
            drop_cnt     <= 2'd0;
            pc_select    <= 1'b0;
            jump_address <= '0;
        end else begin
            pc_select <= take_jump;
            if (take_jump) jump_address <= imem_rdata[ADDR_W-1:0];
            case (state)
                ST_RUN_WAIT: state <= ST_RUN;
                ST_RUN: begin
                    if (take_jump) begin
                        drop_cnt <= 2'(FLUSH_CNT);
                        state    <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (rd_pending) begin
                        drop_cnt <= drop_cnt - 2'd1;
                        if (drop_cnt == 2'd1) state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN_WAIT;
            endcase
        end
    end

    fetch_skid_fifo #(
        .W($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head_data (head_entry),
        .count     (count)
    );

    assign ir.ir_valid = (count != 2'd0);
    assign ir.ir_data  = head_entry.instr;
    assign ir.ir_addr  = head_entry.addr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random ROM/back-pressure against a queue model.
`timescale 1ns/1ps
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int FLUSH_CNT = 2;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [ADDR_W-1:0]  pc_addr;
    logic               pc_started;
    logic               pc_stall;
    logic               pc_select;
    logic [ADDR_W-1:0]  jump_address;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [INSTR_W-1:0] rom [256];
    bit                 checking = 0;

    int total = 0;
    int bad = 0;
    int sel_pulses = 0;
    bit prev_sel = 0;
    fetch_entry_t delivered [$];

    // Reference model state
    fetch_entry_t      m_q [$];
    fetch_entry_t      m_last = '0;
    bit                m_pending = 0;
    logic [ADDR_W-1:0] m_req_addr = '0;
    int                m_phase = 0;
    int                m_drop = 0;
    bit                m_sel = 0;
    logic [ADDR_W-1:0] m_jaddr = '0;

    instr_fetch_if ir_bus ();

    instr_fetch #(.FLUSH_CNT(FLUSH_CNT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pc_addr      (pc_addr),
        .pc_stall     (pc_stall),
        .pc_select    (pc_select),
        .jump_address (jump_address),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .ir           (ir_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    // PC: holds for its first cycle out of reset, then loads on pc_select or steps when not stalled
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_addr    <= '0;
            pc_started <= 1'b0;
        end else begin
            pc_started <= 1'b1;
            if (pc_select)                    pc_addr <= jump_address;
            else if (pc_started && !pc_stall) pc_addr <= pc_addr + 8'd1;
        end
    end

    task automatic model_step();
        bit           pop_now;
        bit           stall_now;
        bit           issue_now;
        bit           is_jmp;
        bit           new_sel;
        fetch_entry_t word;
        pop_now   = (m_q.size() != 0) && ir_bus.ir_ready;
        stall_now = (m_q.size() + int'(m_pending) - int'(pop_now)) >= 2;
        issue_now = !stall_now && (m_phase != 0);
        word.instr = imem_rdata;
        word.addr  = m_req_addr;
        is_jmp  = m_pending && (imem_rdata[15:12] == 4'hF);
        new_sel = 0;
        if (pop_now) m_last = m_q.pop_front();
        case (m_phase)
            0: m_phase = 1;
            1: begin
                if (m_pending) begin
                    if (is_jmp) begin
                        new_sel = 1;
                        m_jaddr = imem_rdata[7:0];
                        m_drop  = FLUSH_CNT;
                        m_phase = 2;
`ifdef FETCH_FWD_JUMP_EN
                        m_q.push_back(word);
`endif
                    end else begin
                        m_q.push_back(word);
                    end
                end
            end
            default: begin
                if (m_pending) begin
                    m_drop--;
                    if (m_drop == 0) m_phase = 1;
                end
            end
        endcase
        m_sel      = new_sel;
        m_pending  = issue_now;
        m_req_addr = pc_addr;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            m_last     = '0;
            m_pending  = 0;
            m_req_addr = '0;
            m_phase    = 0;
            m_drop     = 0;
            m_sel      = 0;
            m_jaddr    = '0;
        end else begin
            model_step();
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        bit           exp_valid;
        bit           exp_stall;
        bit           pop_now;
        fetch_entry_t head;
        exp_valid = (m_q.size() != 0);
        head      = exp_valid ? m_q[0] : m_last;
        pop_now   = exp_valid && ir_bus.ir_ready;
        exp_stall = (m_q.size() + int'(m_pending) - int'(pop_now)) >= 2;
        check_output("ir_valid", ir_bus.ir_valid, exp_valid);
        check_output("ir_data", ir_bus.ir_data, head.instr);
        check_output("ir_addr", ir_bus.ir_addr, head.addr);
        check_output("pc_stall", pc_stall, exp_stall);
        check_output("pc_select", pc_select, m_sel);
        check_output("jump_address", jump_address, m_jaddr);
        check_output("imem_addr", imem_addr, pc_addr);
        check_output("pc_select_repeat", pc_select & prev_sel, 1'b0);
        prev_sel = pc_select;
        if (pc_select) sel_pulses++;
        if (ir_bus.ir_valid && ir_bus.ir_ready) delivered.push_back('{ir_bus.ir_data, ir_bus.ir_addr});
    endtask

    always @(negedge clk) begin
        if (checking) compare_cycle();
    end

    task automatic apply_stimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1 ir_bus.ir_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rstn = 1'b0;
                @(posedge clk);
                #1 rstn = 1'b1;
            end
        end
    endtask

    initial begin
        int need;
        int n;
        logic [INSTR_W-1:0] word;
        ir_bus.ir_ready = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
        rom[0] = 16'h1234;
        rom[1] = 16'h2345;
        rom[2] = 16'h3456;
        rom[3] = 16'hF010;
        rom[4] = 16'hF020;
        rom[5] = 16'h5678;

        repeat (2) @(posedge clk);
        checking = 1;
        @(negedge clk);
        check_output("rst_ir_valid", ir_bus.ir_valid, 0);
        check_output("rst_pc_stall", pc_stall, 0);
        check_output("rst_pc_select", pc_select, 0);
        check_output("rst_jump_address", jump_address, 0);
        check_output("rst_ir_data", ir_bus.ir_data, 0);
        check_output("rst_ir_addr", ir_bus.ir_addr, 0);

        rstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("first_valid", ir_bus.ir_valid, 1);
        check_output("first_data", ir_bus.ir_data, 16'h1234);
        check_output("first_addr", ir_bus.ir_addr, 8'h00);

        @(posedge clk);
        @(negedge clk);
        check_output("bp_stall", pc_stall, 1);
        check_output("bp_pc_addr", pc_addr, 8'h02);
        check_output("bp_head_addr", ir_bus.ir_addr, 8'h00);
        check_output("bp_head_data", ir_bus.ir_data, 16'h1234);

        delivered.delete();
        sel_pulses = 0;
        @(posedge clk);
        #1 ir_bus.ir_ready = 1'b1;
`ifdef FETCH_FWD_JUMP_EN
        need = 5;
`else
        need = 4;
`endif
        n = 0;
        while (delivered.size() < need && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check_output("jump_deliver_timeout", delivered.size() >= need, 1);
        if (delivered.size() >= need) begin
            check_output("order_addr0", delivered[0].addr, 8'h00);
            check_output("order_addr1", delivered[1].addr, 8'h01);
            check_output("order_data1", delivered[1].instr, 16'h2345);
            check_output("order_addr2", delivered[2].addr, 8'h02);
`ifdef FETCH_FWD_JUMP_EN
            check_output("fwd_jump_data", delivered[3].instr, 16'hF010);
            check_output("fwd_jump_addr", delivered[3].addr, 8'h03);
            check_output("after_jump_addr", delivered[4].addr, 8'h10);
`else
            check_output("after_jump_addr", delivered[3].addr, 8'h10);
            check_output("after_jump_data", delivered[3].instr, 16'h1010);
`endif
        end
        check_output("jump_pulses", sel_pulses, 1);
        check_output("jump_target", jump_address, 8'h10);

        @(posedge clk);
        #1 ir_bus.ir_ready = 1'b0;
        n = 0;
        while (!pc_stall && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("fill_timeout", pc_stall, 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check_output("midrst_ir_valid", ir_bus.ir_valid, 0);
        check_output("midrst_pc_stall", pc_stall, 0);
        check_output("midrst_ir_data", ir_bus.ir_data, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("midrst_no_stale", ir_bus.ir_valid, 0);
        end

        for (int pass = 0; pass < 4; pass++) begin
            @(posedge clk);
            #1 rstn = 1'b0;
            for (int i = 0; i < 256; i++) begin
                word = 16'($urandom);
                if ($urandom_range(0, 5) == 0)  word[15:12] = 4'hF;
                else if (word[15:12] == 4'hF)   word[15:12] = 4'h0;
                rom[i] = word;
            end
            @(posedge clk);
            #1 rstn = 1'b1;
            apply_stimulus(600);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly downstream of the 8-bit programme counter in the 16-bit custom processor.
- Drives the PC value to the synchronous instruction ROM and captures the returned 16-bit word with its address.
- Decodes J-type words and returns pc_select/jump_address to the PC.
- Buffers up to 2 instructions in a skid FIFO and presents them to decode/execute over a valid/ready handshake.
- Back-pressures the PC via pc_stall.

Parameters:
- ADDR_W, 8, instruction address width.
- INSTR_W, 16, instruction width.
- OPC_W, 4, opcode field width (instr[INSTR_W-1 -: OPC_W]).
- JMP_OPC, 4'hF, opcode identifying a J-type instruction.
- FLUSH_CNT, 2, returned words discarded after a jump is taken (range 1..3).

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- pc_addr  in  ADDR_W  current instruction address from PC
- pc_stall  out  1  PC holds its address while high
- pc_select  out  1  one-cycle pulse: load jump_address into PC
- jump_address  out  ADDR_W  jump target, instr[ADDR_W-1:0]
- imem_addr  out  ADDR_W  ROM read address
- imem_rdata  in  INSTR_W  ROM data, valid one cycle after imem_addr
- ir_valid  out  1  FIFO head valid
- ir_ready  in  1  downstream accepts head
- ir_data  out  INSTR_W  head instruction
- ir_addr  out  ADDR_W  head instruction address

Behaviour:
- Reset is asynchronous, active-low on rstn; clock is clk. Reset clears FIFO (count=0), rd_pending=0, drop_cnt=0, and state=RUN_WAIT. All outputs are 0: pc_stall, pc_select, jump_address, ir_valid, ir_data, ir_addr.
- imem_addr = pc_addr, combinational.
- A read is issued in every cycle where !pc_stall and state!=RUN_WAIT. rd_pending<=issued; req_addr<=pc_addr.
- Returned word (rd_pending=1) is valid the following cycle; ROM latency is fixed at 1.
- pc_stall = (count + rd_pending - pop) >= 2, where pop = ir_valid & ir_ready. The FIFO therefore never overflows.
- FIFO: 2 entries {instr, addr}, in-order. Simultaneous push and pop are allowed at any count. When the FIFO is empty, ir_valid=0 and ir_data/ir_addr hold their last value.
- Handshake: ir_data/ir_addr stay stable while ir_valid & !ir_ready. ir_valid never drops without a pop.
- FSM states:
  - RUN_WAIT: first cycle after reset, no issue → RUN.
  - RUN: normal operation.
  - FLUSH: discard returned words.
- Transitions:
  - RUN, returned word with opcode==JMP_OPC:
    - pc_select=1 for exactly that cycle; jump_address=instr[ADDR_W-1:0] (registered, held after the pulse).
    - drop_cnt<=FLUSH_CNT; → FLUSH.
    - The jump word is not pushed (see optional feature).
  - FLUSH: each returned word is discarded, including any J-type, and decrements drop_cnt. When drop_cnt reaches 0 → RUN.
    - Cycles without a returned word do not decrement.
- Entries already in the FIFO before a jump are older and remain valid; they are never flushed.
- pc_select is never asserted in consecutive cycles.
- A jump to its own address (tight loop) is legal. Wrap-around at 8'hFF is the PC's responsibility; this block never modifies addresses.
- Reset mid-operation discards all FIFO contents and any pending read immediately.

Optional Feature:
Macro FETCH_FWD_JUMP_EN.
- Defined: J-type words are also pushed into the FIFO, so downstream sees the jump (for link/trace).
  - pc_stall accounts for the push.
  - If the FIFO is full, it cannot accept the word; that is guaranteed impossible by pc_stall.
- Undefined: J-type words are consumed in fetch only.

Decomposition:
- Package instr_fetch_pkg: ADDR_W/INSTR_W/OPC_W constants, JMP_OPC, FSM state enum {RUN_WAIT, RUN, FLUSH}, typedef fetch_entry_t {instr, addr}.
- One sub-module: fetch_skid_fifo (2-entry, push/pop/count, parameterised entry width).

Test Plan:
- Reset and first fetch: rstn low with pc_addr=8'h00 → all outputs 0. Release reset, ROM[0]=16'h1234 → ir_valid=1, ir_data=16'h1234, ir_addr=8'h00 three cycles after rstn rises.
- Back-pressure: ir_ready=0, sequential PC 0,1,2 → FIFO holds ROM[0],ROM[1]; pc_stall=1 with pc_addr=2. No word lost after ir_ready=1; addresses come out 0,1,2 in order.
- Jump: ROM[3]=16'hF010, FLUSH_CNT=2 → pc_select pulse of exactly 1 cycle, jump_address=8'h10. Words from addr 4 and 5 are discarded. Next ir_addr after 3's predecessor is 8'h10.
- Jump during FLUSH: ROM[4]=16'hF020 following the jump at 3 → no second pc_select; execution continues at 8'h10.
- Mid-operation reset: FIFO full, rstn pulsed low for 1 cycle → ir_valid=0 and pc_stall=0 immediately; no stale word appears after release.
- FETCH_FWD_JUMP_EN defined: same ROM as the jump test → ir_data=16'hF010 with ir_addr=8'h03 delivered, followed by ir_addr=8'h10.
